// File: rtl/uart_rx_monitor.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, show-ahead byte FIFO with valid/ready.
// Optional feature macro: UART_RX_MONITOR_PARITY_EN (even parity bit between bit 7 and stop).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rxs low while enabled
// START     | half-bit wait, confirm start bit (rxs high = false start)
// DATA      | eight samples one bit time apart, LSB first
// PARITY    | even parity sample (only with UART_RX_MONITOR_PARITY_EN)
// STOP      | stop sample: high pushes the byte, low flags frame error
// WAIT_HIGH | after bad stop, hold until the line returns high
module uart_rx_monitor #(
  parameter int unsigned ClkFreq   = 30_000_000,
  parameter int unsigned BaudRate  = 921_600,
  parameter int unsigned FifoDepth = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             rx_i,
  input  logic                             enable_i,
  output logic [7:0]                       byte_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             frame_err_o,
  output logic                             overflow_o,
  output logic [$clog2(FifoDepth+1)-1:0]   level_o,
  output logic                             busy_o
);

  localparam int unsigned C    = ClkFreq / BaudRate;
  localparam int unsigned H    = C / 2;
  localparam int unsigned CntW = $clog2(C);
  localparam int unsigned AW   = $clog2(FifoDepth);
  localparam int unsigned LW   = $clog2(FifoDepth + 1);

  // Counters are loaded one short because the load cycle itself counts as a wait cycle.
  localparam logic [CntW-1:0] CntFull = CntW'(C - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(H - 1);

`ifdef UART_RX_MONITOR_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rxs;
  logic            tick;
  logic            push;
  logic            err_d, err_q;
  logic            ovf_q;
`ifdef UART_RX_MONITOR_PARITY_EN
  logic            par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs       <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    err_d     = 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    tick = (cnt_q == '0);
    if (!tick) cnt_d = cnt_q - CntW'(1);

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          cnt_d     = CntHalf;
`ifdef UART_RX_MONITOR_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = CntFull;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = CntFull;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_MONITOR_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_MONITOR_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_d = rxs ^ (^shift_q);
          err_d     = par_bad_d;
          cnt_d     = CntFull;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rxs) begin
`ifdef UART_RX_MONITOR_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disabling abandons the frame silently; the FIFO is left alone.
    if (!enable_i) begin
      state_d = IDLE;
      push    = 1'b0;
      err_d   = 1'b0;
    end
  end

  logic [7:0]    mem_q [FifoDepth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, pop, do_push;

  assign full    = (level_q == LW'(FifoDepth));
  assign empty   = (level_q == '0);
  assign pop     = ready_i && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= push && !do_push;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign byte_o      = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign valid_o     = !empty;
  assign level_o     = level_q;
  assign frame_err_o = err_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor: directed framing/FIFO cases plus randomized frames.
module tb_uart_rx_monitor;
  localparam int ClkFreq   = 30_000_000;
  localparam int BaudRate  = 921_600;
  localparam int FifoDepth = 16;
  localparam int C  = ClkFreq / BaudRate;
  localparam int H  = C / 2;
  localparam int LW = $clog2(FifoDepth + 1);
`ifdef UART_RX_MONITOR_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Cycles from driving the start edge on rx_i to the stop-bit sample.
  localparam int STOP_OFF = 2 + H + C * NB;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          rx_i = 1'b1;
  logic          enable_i = 1'b1;
  logic [7:0]    byte_o;
  logic          valid_o;
  logic          ready_i;
  logic          frame_err_o;
  logic          overflow_o;
  logic [LW-1:0] level_o;
  logic          busy_o;

  logic ready_force = 1'b0;
  logic rnd_mode = 1'b0;
  logic rnd_bit = 1'b0;
  assign ready_i = rnd_mode ? rnd_bit : ready_force;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_seen = 0, err_exp = 0;
  int ovf_seen = 0, ovf_exp = 0;
  logic [7:0] sb[$];

  uart_rx_monitor #(.ClkFreq(ClkFreq), .BaudRate(BaudRate), .FifoDepth(FifoDepth)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .enable_i(enable_i),
    .byte_o(byte_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o),
    .level_o(level_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  always @(posedge clk_i) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted byte is compared against the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (frame_err_o) err_seen++;
      if (overflow_o) ovf_seen++;
      if (valid_o && ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte actual=%02h expected=none", byte_o);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (byte_o !== e) begin
            failures++;
            $display("FAIL byte_data actual=%02h expected=%02h", byte_o, e);
          end
        end
      end
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drives one frame; stop level held for stop_bits bit times, then line returns high.
  task automatic send(input logic [7:0] b, input int stop_bits, input logic stop_val,
                      input logic bad_par);
    rx_i = 1'b0;
    hold(C);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      hold(C);
    end
`ifdef UART_RX_MONITOR_PARITY_EN
    rx_i = (^b) ^ bad_par;
    hold(C);
`else
    if (bad_par) rx_i = 1'b1;
`endif
    rx_i = stop_val;
    hold(C * stop_bits);
    rx_i = 1'b1;
  endtask

  // Reference rule: a good frame lands in the FIFO if there is room, else it overflows.
  task automatic exp_push(input logic [7:0] b);
    if (sb.size() < FifoDepth) sb.push_back(b);
    else ovf_exp++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_force = 1'b1;
    while ((sb.size() != 0 || valid_o) && n < 4000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    ready_force = 1'b0;
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_valid_low", int'(valid_o), 0);
  endtask

  initial begin
    int p;
    hold(3);
    @(negedge clk_i);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_level", int'(level_o), 0);
    chk("rst_byte", int'(byte_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_pulses", int'(frame_err_o) + int'(overflow_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    hold(5);

    // 0xA5, consumer stalled: push latency check
    p = cyc;
    exp_push(8'hA5);
    fork
      send(8'hA5, 1, 1'b1, 1'b0);
      begin
        wait_cyc(p + STOP_OFF);
        @(negedge clk_i);
        chk("a5_valid_before", int'(valid_o), 0);
        wait_cyc(p + STOP_OFF + 1);
        @(negedge clk_i);
        chk("a5_valid_after", int'(valid_o), 1);
        chk("a5_byte", int'(byte_o), 8'hA5);
        chk("a5_level", int'(level_o), 1);
      end
    join
    hold(C);
    chk("a5_no_err", err_seen, err_exp);
    chk("a5_no_ovf", ovf_seen, ovf_exp);
    drain();

    // false start: 8 low cycles
    p = cyc;
    rx_i = 1'b0;
    hold(8);
    rx_i = 1'b1;
    wait_cyc(p + 6);
    @(negedge clk_i);
    chk("fs_busy_mid", int'(busy_o), 1);
    wait_cyc(p + 2 + H + 2);
    @(negedge clk_i);
    chk("fs_busy_end", int'(busy_o), 0);
    hold(C);
    chk("fs_no_err", err_seen, err_exp);
    chk("fs_level", int'(level_o), 0);

    // break-like stop, then a clean frame
    send(8'h3C, 3, 1'b0, 1'b0);
    err_exp++;
    hold(C);
    chk("brk_err_once", err_seen, err_exp);
    chk("brk_level", int'(level_o), 0);
    exp_push(8'h11);
    send(8'h11, 1, 1'b1, 1'b0);
    hold(C);
    chk("brk_next_level", int'(level_o), 1);
    drain();

    // overflow: 17 back-to-back bytes into a stalled FIFO
    for (int i = 0; i <= FifoDepth; i++) begin
      exp_push(8'(i));
      send(8'(i), 1, 1'b1, 1'b0);
    end
    hold(C);
    chk("ovf_level", int'(level_o), FifoDepth);
    chk("ovf_count", ovf_seen, ovf_exp);
    chk("ovf_count_one", ovf_exp, 1);

    // full FIFO, pop lands on the push cycle
    p = cyc;
    sb.push_back(8'h55);
    fork
      send(8'h55, 1, 1'b1, 1'b0);
      begin
        wait_cyc(p + STOP_OFF);
        ready_force = 1'b1;
        wait_cyc(p + STOP_OFF + 1);
        ready_force = 1'b0;
        @(negedge clk_i);
        chk("pp_level", int'(level_o), FifoDepth);
      end
    join
    hold(C);
    chk("pp_no_ovf", ovf_seen, ovf_exp);
    drain();

    // enable dropped mid-frame
    p = cyc;
    fork
      send(8'h99, 1, 1'b1, 1'b0);
      begin
        wait_cyc(p + 3 * C + 3);
        enable_i = 1'b0;
        wait_cyc(p + 3 * C + 5);
        @(negedge clk_i);
        chk("en_busy", int'(busy_o), 0);
      end
    join
    hold(2);
    enable_i = 1'b1;
    hold(C);
    chk("en_level", int'(level_o), 0);
    chk("en_no_err", err_seen, err_exp);

    // reset mid-frame empties FIFO and discards the frame
    exp_push(8'h42);
    send(8'h42, 1, 1'b1, 1'b0);
    p = cyc;
    fork
      send(8'hF0, 1, 1'b1, 1'b0);
      begin
        wait_cyc(p + 5 * C + 4);
        rst_ni = 1'b0;
        sb.delete();
      end
    join
    hold(4);
    rst_ni = 1'b1;
    hold(2);
    chk("mrst_level", int'(level_o), 0);
    chk("mrst_valid", int'(valid_o), 0);
    exp_push(8'h7E);
    send(8'h7E, 1, 1'b1, 1'b0);
    hold(C);
    chk("mrst_7e_level", int'(level_o), 1);
    chk("mrst_no_err", err_seen, err_exp);
    drain();
`ifdef UART_RX_MONITOR_PARITY_EN
    send(8'h7E, 1, 1'b1, 1'b1);
    err_exp++;
    hold(C);
    chk("par_err", err_seen, err_exp);
    chk("par_level", int'(level_o), 0);
`endif

    // randomized frames with a randomly stalling consumer
    rnd_mode = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        err_exp++;
        send(b, 2, 1'b0, 1'b0);
        hold(C);
`ifdef UART_RX_MONITOR_PARITY_EN
      end else if (kind == 1) begin
        err_exp++;
        send(b, 1, 1'b1, 1'b1);
`endif
      end else begin
        exp_push(b);
        send(b, 1, 1'b1, 1'b0);
      end
      hold(int'($urandom_range(0, 40)));
    end
    hold(C);
    rnd_mode = 1'b0;
    drain();
    chk("final_err", err_seen, err_exp);
    chk("final_ovf", ovf_seen, ovf_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
